// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared types and helpers for the chunked sequential adder.
// Holds the controller state encoding and the per-operation cycle count helper.
package seq_adder_pkg;

    // Controller states of the sequential adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to walk a WIDTH-bit operand in CHUNK-bit steps.
    function automatic int unsigned chunk_cycles(input int unsigned width,
                                                 input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/seq_adder_fa_chunk.sv
// fa_chunk: combinational CHUNK-bit ripple adder built from per-bit full-adder
// equations. Besides the sum and carry-out it exposes the carry entering its
// most significant bit, which the top uses for two's-complement overflow.
module fa_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // Ripple the carry through the chunk one full adder at a time.
    always_comb begin
        logic v_c;
        v_c   = ci;
        s     = '0;
        c_msb = ci;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = v_c;
            end
            s[i] = x[i] ^ y[i] ^ v_c;
            v_c  = (x[i] & y[i]) | (y[i] & v_c) | (x[i] & v_c);
        end
        co = v_c;
    end

endmodule

// File: rtl/seq_adder.sv
// seq_adder: sequential adder that computes a+b+cin over WIDTH/CHUNK clock
// cycles, CHUNK bits per cycle, with a valid/ready handshake on both sides.
// Optional feature: define SEQ_ADDER_OVF_EN to add the ovf output
// (two's-complement overflow of the full-width addition).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1, captures a/b/cin on in_valid
// RUN   | adding one CHUNK-bit slice per cycle, carry rippled via r_carry
// DONE  | result held on sum/cout(/ovf) with out_valid=1 until out_ready
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCYC  = int'(chunk_cycles(WIDTH, CHUNK));
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCYC - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    // Reject parameter sets that cannot be split into whole chunks.
    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
            $error("seq_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_last;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;

    // Bit offset of the slice being worked on; slices are selected by shifting
    // so the same datapath serves every CHUNK/WIDTH combination.
    assign w_base = 32'(r_cnt) * 32'(CHUNK);
    assign w_x    = CHUNK'(r_a >> w_base);
    assign w_y    = CHUNK'(r_b >> w_base);
    assign w_last = (r_cnt == LAST_CNT);

    fa_chunk #(
        .CHUNK (CHUNK)
    ) u_fa_chunk (
        .x     (w_x),
        .y     (w_y),
        .ci    (r_carry),
        .s     (w_s),
        .co    (w_co),
`ifdef SEQ_ADDER_OVF_EN
        .c_msb (w_c_msb)
`else
        .c_msb ()
`endif
    );

`ifndef SEQ_ADDER_OVF_EN
    assign w_c_msb = 1'b0;
`endif

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, slice-by-slice sum accumulation and carry propagation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= (r_sum & ~(CHUNK_MASK << w_base)) | (WIDTH'(w_s) << w_base);
                    r_carry <= w_co;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_cout <= w_co;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    logic r_ovf;

    // Overflow is latched with the last slice, alongside cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_ovf <= w_c_msb ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand and sum width in bits.
REQ-002 Parameter: CHUNK, 1, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; CHUNK SHALL be between 1 and WIDTH.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  operands a, b, cin are valid.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: a  input  WIDTH  operand A, unsigned.
REQ-008 Port: b  input  WIDTH  operand B, unsigned.
REQ-009 Port: cin  input  1  carry-in.
REQ-010 Port: out_valid  output  1  sum/cout valid.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-013 Port: cout  output  1  carry-out of the full WIDTH-bit addition.

Function
REQ-014 The block SHALL use a 3-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1 the block SHALL register a, b, cin, clear chunk counter to 0 and go to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle the block SHALL add chunk [cnt*CHUNK +: CHUNK] of the registered operands plus the carry register, write the result into the same slice of sum, update the carry register and increment cnt.
REQ-017 The carry register SHALL be loaded with cin on acceptance and SHALL propagate between chunks.
REQ-018 After the chunk with cnt=WIDTH/CHUNK-1 the block SHALL go to DONE; cout SHALL equal the final carry.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH/CHUNK cycles after the accepting edge.
REQ-020 DONE: out_valid=1, in_ready=0; sum and cout SHALL hold stable until out_ready=1, then return to IDLE on that edge.
REQ-021 in_valid while in_ready=0 SHALL be ignored; a, b, cin changes during RUN/DONE SHALL NOT affect the result.
REQ-022 CHUNK=WIDTH SHALL give one RUN cycle (latency 1).

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, cnt=0, carry=0, sum=0, cout=0, out_valid=0, in_ready=1, from any state including mid-RUN; the in-flight operation SHALL be discarded.
REQ-024 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-025 Macro SEQ_ADDER_OVF_EN: when defined, the block SHALL add output port ovf (1 bit), equal to carry into bit WIDTH-1 XOR cout (two's-complement overflow), valid and held under the same rules as cout, reset to 0.
REQ-026 Without SEQ_ADDER_OVF_EN the ovf port and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-027 Package seq_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and a function returning the cycle count WIDTH/CHUNK.
REQ-028 The per-cycle CHUNK-bit add SHALL be a sub-module fa_chunk (parameter CHUNK; inputs x, y, ci; outputs s, co, and c_msb = carry into its top bit), built from per-bit full-adder equations s=x^y^c, co=x&y|y&c|x&c.

Verification
REQ-029 WIDTH=8, CHUNK=1: a=0x5A, b=0xA5, cin=1 -> out_valid 8 cycles after accept, sum=0x00, cout=1.
REQ-030 WIDTH=8, CHUNK=4: a=0xFF, b=0x01, cin=0 -> out_valid 2 cycles after accept, sum=0x00, cout=1; then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> sum/cout unchanged, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-032 Reset mid-RUN: assert rst at cnt=3 (WIDTH=8, CHUNK=1) -> next cycle IDLE, sum=0, cout=0, out_valid=0, in_ready=1; no result emitted.
REQ-033 SEQ_ADDER_OVF_EN defined, WIDTH=8, CHUNK=2: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.
REQ-034 Randomised cross-check, WIDTH=16, CHUNK in {1,2,4,8,16}: 1000 operand sets with random in_valid/out_ready -> {cout,sum} equals a+b+cin for every transaction, latency per REQ-019.
